// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-requester arbiter.
package arb_pkg;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   typedef enum logic {IDLE, OWN} state_t;
endpackage

// File: rtl/arb_msb_pick4.sv
// Combinational MSB-first pick over a 4-bit vector, with the search order
// rotated by ptr so that requester ptr-1 is searched first and ptr last.
module arb_msb_pick4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] v,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [ID_W-1:0]  idx,
   output logic             found
);
   logic [N_REQ-1:0] rot;
   logic [ID_W-1:0]  ridx;

   // rot[j] = v[j+ptr]: position 3 holds requester ptr-1, position 0 holds ptr.
   always_comb begin
      rot = '0;
      for (int j = 0; j < N_REQ; j++)
         rot[j] = v[ID_W'(j) + ptr];
   end

   always_comb begin
      ridx = '0;
      for (int j = 0; j < N_REQ; j++)
         if (rot[j]) ridx = ID_W'(j);
   end

   assign found  = |rot;
   assign idx    = ridx + ptr;
   assign onehot = found ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/msb_req_arbiter4.sv
// Locking 4-way arbiter with hold-time expiry; registered one-hot grant.
// Define ARB_ROUND_ROBIN_EN to rotate priority after each new grant.
module msb_req_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_vld
);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
   logic [N_REQ-1:0] gnt_n;
   logic [ID_W-1:0]  gnt_id_n;
   logic             gnt_vld_n;
   logic [ID_W-1:0]  ptr;

   logic [N_REQ-1:0] others;
   logic [N_REQ-1:0] req_oh, oth_oh;
   logic [ID_W-1:0]  req_idx, oth_idx;
   logic             req_found, oth_found;

   assign others = req & ~gnt;

   arb_msb_pick4 u_pick_req (
      .v      (req),
      .ptr    (ptr),
      .onehot (req_oh),
      .idx    (req_idx),
      .found  (req_found)
   );

   arb_msb_pick4 u_pick_oth (
      .v      (others),
      .ptr    (ptr),
      .onehot (oth_oh),
      .idx    (oth_idx),
      .found  (oth_found)
   );

   always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      gnt_n      = gnt;
      gnt_id_n   = gnt_id;
      gnt_vld_n  = gnt_vld;
      case (state)
         IDLE: begin
            if (req_found) begin
               state_n    = OWN;
               gnt_n      = req_oh;
               gnt_id_n   = req_idx;
               gnt_vld_n  = 1'b1;
               hold_cnt_n = '0;
            end
         end
         OWN: begin
            if ((req & gnt) == '0) begin
               // Owner released: hand over directly, no idle bubble.
               hold_cnt_n = '0;
               if (req_found) begin
                  gnt_n     = req_oh;
                  gnt_id_n  = req_idx;
                  gnt_vld_n = 1'b1;
               end else begin
                  state_n   = IDLE;
                  gnt_n     = '0;
                  gnt_id_n  = '0;
                  gnt_vld_n = 1'b0;
               end
            end else if (hold_cnt < HOLD_LAST) begin
               hold_cnt_n = hold_cnt + 1'b1;
            end else begin
               // Hold expired: pass on only if someone else is waiting.
               hold_cnt_n = '0;
               if (oth_found) begin
                  gnt_n    = oth_oh;
                  gnt_id_n = oth_idx;
               end
            end
         end
         default: begin
            state_n    = IDLE;
            hold_cnt_n = '0;
            gnt_n      = '0;
            gnt_id_n   = '0;
            gnt_vld_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         gnt      <= '0;
         gnt_id   <= '0;
         gnt_vld  <= 1'b0;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_cnt_n;
         gnt      <= gnt_n;
         gnt_id   <= gnt_id_n;
         gnt_vld  <= gnt_vld_n;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Every new grant goes to a different requester than before, so a
   // change of the one-hot grant to non-zero marks a new winner.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (gnt_vld_n && (gnt_n != gnt))
         ptr <= gnt_id_n;
   end
`else
   assign ptr = '0;
`endif
endmodule

// File: tb/tb_msb_req_arbiter4.sv
// Directed vector table plus MAX_HOLD=1 sequence and a random invariant check.
module tb_msb_req_arbiter4;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, req1;
   logic [3:0] gnt, gnt1;
   logic [1:0] gnt_id, gnt_id1;
   logic       gnt_vld, gnt_vld1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   msb_req_arbiter4 #(.MAX_HOLD(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld)
   );

   msb_req_arbiter4 #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1),
      .gnt(gnt1), .gnt_id(gnt_id1), .gnt_vld(gnt_vld1)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       vld;
   } vec_t;

   vec_t       tbl[$];
   logic [3:0] seq1[$];

   task automatic chk4(string name, logic [3:0] got, logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic step(logic r, logic [3:0] q, logic [3:0] q1);
      @(negedge clk);
      rst  = r;
      req  = q;
      req1 = q1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] enc(logic [3:0] g);
      logic [1:0] e = 2'd0;
      for (int k = 0; k < 4; k++) if (g[k]) e = 2'(k);
      return e;
   endfunction

   initial begin
      rst = 1'b1; req = 4'b0; req1 = 4'b0;

      // reset held with all requests pending
      tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0});
      // lone requester keeps grant forever
      for (int i = 0; i < 10; i++)
         tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
      tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
      tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0});
      // hold expiry after 4 cycles
      for (int i = 0; i < 4; i++)
         tbl.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1});
      tbl.push_back('{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1});
      tbl.push_back('{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1});
      tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
      // no preemption, then release hand-over without bubble
      tbl.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1});
      tbl.push_back('{1'b0, 4'b0111, 4'b0010, 2'd1, 1'b1});
`ifdef ARB_ROUND_ROBIN_EN
      tbl.push_back('{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1});
`else
      tbl.push_back('{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1});
`endif
      // reset mid-grant
      tbl.push_back('{1'b1, 4'b0101, 4'b0000, 2'd0, 1'b0});
      tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].req, 4'b0000);
         chk4($sformatf("vec%0d gnt", i), gnt, tbl[i].gnt);
         chk4($sformatf("vec%0d gnt_id", i), {2'b00, gnt_id}, {2'b00, tbl[i].id});
         chk4($sformatf("vec%0d gnt_vld", i), {3'b000, gnt_vld}, {3'b000, tbl[i].vld});
      end

      // MAX_HOLD=1 with all four requesting constantly
`ifdef ARB_ROUND_ROBIN_EN
      seq1 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
`else
      seq1 = '{4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100};
`endif
      step(1'b1, 4'b0000, 4'b0000);
      chk4("hold1 reset", gnt1, 4'b0000);
      foreach (seq1[i]) begin
         step(1'b0, 4'b0000, 4'b1111);
         chk4($sformatf("hold1 cyc%0d gnt", i), gnt1, seq1[i]);
         chk4($sformatf("hold1 cyc%0d id", i), {2'b00, gnt_id1}, {2'b00, enc(seq1[i])});
      end

      // random requests: structural invariants on both instances
      step(1'b1, 4'b0000, 4'b0000);
      begin
         logic [3:0] pg = 4'b0000;
         logic [3:0] pg1 = 4'b0000;
         for (int i = 0; i < 300; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            chk4("rnd onehot", {3'b000, $onehot0(gnt)}, 4'b0001);
            chk4("rnd id", {2'b00, gnt_id}, {2'b00, enc(gnt)});
            chk4("rnd vld", {3'b000, gnt_vld}, {3'b000, |gnt});
            chk4("rnd1 onehot", {3'b000, $onehot0(gnt1)}, 4'b0001);
            chk4("rnd1 id", {2'b00, gnt_id1}, {2'b00, enc(gnt1)});
            chk4("rnd1 vld", {3'b000, gnt_vld1}, {3'b000, |gnt1});
            if (gnt != 4'b0000 && gnt != pg)
               chk4("rnd grant to requester", gnt & req, gnt);
            if (gnt1 != 4'b0000 && gnt1 != pg1)
               chk4("rnd1 grant to requester", gnt1 & req1, gnt1);
            pg  = gnt;
            pg1 = gnt1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
